io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
// Peripheral-side end of the MCU port bus: decodes PORT_ID/IO_STRB/OUT_PORT
// writes into output registers and returns IN_PORT data for IN instructions.
// Synchronizes board switches/buttons, latches button-press events as maskable
// interrupt requests, and provides a prescaled 8-bit free-running tick timer.
// Sits between the MCU top level and board I/O (LEDs, 7-seg, switches, buttons).
// PARAMETERS
// SW_ID     8'h20  read: synchronized switches
// BTN_ID    8'h24  read: synchronized buttons (bits 3:0, upper bits 0)
// IST_ID    8'h25  read: interrupt pending bits (bits 3:0, upper bits 0)
// TMR_ID    8'h30  read: tick counter; write: load tick counter
// LED_ID    8'h40  write: LED register
// SSEG_ID   8'h81  write: 7-seg data register
// ICLR_ID   8'h82  write: write-1-to-clear pending bits [3:0]
// IMSK_ID   8'h83  write: interrupt mask [3:0] (1 = enabled)
// PRESCALE  16'd50000  clocks per timer tick, legal range 1..65535
// PORTS
// CLK        in   1  system clock, all state on rising edge
// RESET      in   1  synchronous, active-high reset
// PORT_ID    in   8  port address from MCU
// OUT_PORT   in   8  write data from MCU
// IO_STRB    in   1  write strobe, one CLK wide per OUT instruction
// IN_PORT    out  8  read data to MCU, combinational on PORT_ID
// SWITCHES   in   8  raw asynchronous board switches
// BUTTONS    in   4  raw asynchronous board buttons, active-high
// LEDS       out  8  LED register
// SSEG       out  8  7-seg data register
// INT_REQ    out  1  interrupt request to MCU, registered
// BEHAVIOUR
// - Reset (RESET=1 at edge): LEDS, SSEG, mask, pending, tick counter, prescaler,
//   sync/edge flops all 0; INT_REQ=0 next cycle. Reset wins over any write/event,
//   including mid-prescale; no event, write or tick is retained across it.
// - Write: at CLK edge with IO_STRB=1, register selected by PORT_ID loads
//   OUT_PORT; visible on outputs the following cycle. Unmapped IDs ignored.
//   IO_STRB=0 -> no register changes regardless of PORT_ID.
// - Read: IN_PORT = mux(PORT_ID) of registered sources, zero latency
//   (MCU samples it in the same cycle). Unmapped IDs -> 8'h00. Reads are
//   side-effect free (reading IST_ID does not clear pending).
// - Inputs: SWITCHES/BUTTONS pass 2-flop synchronizer, so a change is readable
//   2 cycles later; third flop on BUTTONS for rising-edge detect.
// - Pending[i] sets on synchronized 0->1 of BUTTONS[i] (one event per press,
//   held button does not re-set after clear). Independent of mask.
// - ICLR write clears pending bits where OUT_PORT[i]=1. Same-cycle set and
//   clear of one bit: set wins (event never lost).
// - INT_REQ registered = |(pending & mask), so 1 cycle after pending/mask update.
// - Timer: prescaler counts 0..PRESCALE-1, tick at terminal count; tick
//   increments counter, 8'hFF wraps to 8'h00. TMR write loads counter and
//   restarts prescaler at 0; write beats a same-cycle tick.
// - No handshake beyond IO_STRB; responder always ready, never stalls MCU.
// TESTING
// - Reset: drive writes to all IDs, assert RESET -> LEDS=SSEG=0, IN_PORT@IST=0,
//   INT_REQ=0, TMR reads 0.
// - Write/read: IO_STRB with PORT_ID=40,OUT_PORT=A5 -> LEDS=A5 next cycle;
//   PORT_ID=40 with IO_STRB=0, data 3C -> LEDS stays A5; read ID 7F -> 00.
// - Sync latency: SWITCHES 00->5A -> IN_PORT@20 reads 5A exactly 2 cycles later.
// - Interrupt: mask=01, press BUTTONS[0] 10 cycles -> IST=01, INT_REQ=1 once;
//   write ICLR=01 while held -> IST=00, INT_REQ=0, no re-set until re-press.
// - Set/clear collision: ICLR=02 in the same cycle BUTTONS[1] edge is detected
//   -> pending[1]=1; mask=00 -> INT_REQ=0 though IST=02.
// - Timer: PRESCALE=4, load TMR=FE -> reads FF after 4 cycles, 00 after 8 (wrap);
//   RESET at cycle 6 -> reads 00 and restarts full prescale.

Source files
------------

// File: rtl/io_port_responder.sv
// Peripheral end of the MCU port bus: write-decoded output registers, a zero-latency
// read mux, synchronized board inputs, button interrupts and a prescaled tick timer.
module io_port_responder #(
  parameter logic [7:0]  SW_ID    = 8'h20,
  parameter logic [7:0]  BTN_ID   = 8'h24,
  parameter logic [7:0]  IST_ID   = 8'h25,
  parameter logic [7:0]  TMR_ID   = 8'h30,
  parameter logic [7:0]  LED_ID   = 8'h40,
  parameter logic [7:0]  SSEG_ID  = 8'h81,
  parameter logic [7:0]  ICLR_ID  = 8'h82,
  parameter logic [7:0]  IMSK_ID  = 8'h83,
  parameter logic [15:0] PRESCALE = 16'd50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG,
  output logic       INT_REQ
);

  logic [7:0]  sw_s1, sw_s2;
  logic [3:0]  btn_s1, btn_s2, btn_s3;
  logic [3:0]  pending, mask;
  logic [3:0]  btn_rise, iclr_bits, pending_nxt;
  logic [15:0] presc_cnt;
  logic [7:0]  tick_cnt;
  logic        tick;
  logic        wr_led, wr_sseg, wr_iclr, wr_imsk, wr_tmr;

  assign wr_led  = IO_STRB && (PORT_ID == LED_ID);
  assign wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
  assign wr_iclr = IO_STRB && (PORT_ID == ICLR_ID);
  assign wr_imsk = IO_STRB && (PORT_ID == IMSK_ID);
  assign wr_tmr  = IO_STRB && (PORT_ID == TMR_ID);

  // A new press is ORed in after the clear so a colliding event is never lost.
  assign btn_rise    = btn_s2 & ~btn_s3;
  assign iclr_bits   = wr_iclr ? OUT_PORT[3:0] : 4'h0;
  assign pending_nxt = (pending & ~iclr_bits) | btn_rise;

  assign tick = (presc_cnt == (PRESCALE - 16'd1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_s1   <= 8'h00;
      sw_s2   <= 8'h00;
      btn_s1  <= 4'h0;
      btn_s2  <= 4'h0;
      btn_s3  <= 4'h0;
      LEDS    <= 8'h00;
      SSEG    <= 8'h00;
      mask    <= 4'h0;
      pending <= 4'h0;
      INT_REQ <= 1'b0;
    end else begin
      sw_s1   <= SWITCHES;
      sw_s2   <= sw_s1;
      btn_s1  <= BUTTONS;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      if (wr_led)  LEDS <= OUT_PORT;
      if (wr_sseg) SSEG <= OUT_PORT;
      if (wr_imsk) mask <= OUT_PORT[3:0];
      pending <= pending_nxt;
      INT_REQ <= |(pending & mask);
    end
  end

  // A timer load restarts the prescale window and takes priority over a tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_cnt <= 16'd0;
      tick_cnt  <= 8'h00;
    end else if (wr_tmr) begin
      presc_cnt <= 16'd0;
      tick_cnt  <= OUT_PORT;
    end else if (tick) begin
      presc_cnt <= 16'd0;
      tick_cnt  <= tick_cnt + 8'h01;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      SW_ID:   IN_PORT = sw_s2;
      BTN_ID:  IN_PORT = {4'h0, btn_s2};
      IST_ID:  IN_PORT = {4'h0, pending};
      TMR_ID:  IN_PORT = tick_cnt;
      default: IN_PORT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: vector table through a scoreboard
// queue, plus hand-written sequences for sync, interrupt and timer corners.
module tb_io_port_responder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic [7:0] SWITCHES;
  logic [3:0] BUTTONS;
  logic [7:0] LEDS;
  logic [7:0] SSEG;
  logic       INT_REQ;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int SEL_LEDS = 0;
  localparam int SEL_SSEG = 1;
  localparam int SEL_IN   = 2;
  localparam int SEL_INT  = 3;

  typedef struct {
    logic       strb;
    logic [7:0] id;
    logic [7:0] data;
    int         sel;
    logic [7:0] rd_id;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    int         sel;
    logic [7:0] rd_id;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  io_port_responder #(.PRESCALE(16'd4)) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .SWITCHES(SWITCHES),
    .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG(SSEG), .INT_REQ(INT_REQ)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input int sel, input logic [7:0] rd_id, input logic [7:0] exp,
                      input string name);
    exp_t e;
    e.sel = sel; e.rd_id = rd_id; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = 8'h00;
      case (e.sel)
        SEL_LEDS: act = LEDS;
        SEL_SSEG: act = SSEG;
        SEL_IN: begin
          PORT_ID = e.rd_id;
          #1;
          act = IN_PORT;
        end
        default: act = {7'b0, INT_REQ};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %02h, expected %02h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic check_now(input int sel, input logic [7:0] rd_id, input logic [7:0] exp,
                           input string name);
    push(sel, rd_id, exp, name);
    drain();
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    IO_STRB = 1'b1; PORT_ID = id; OUT_PORT = data;
    @(negedge CLK);
    IO_STRB = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h40, 8'hA5, SEL_LEDS, 8'h00, 8'hA5, "led_write"};
    vecs[1] = '{1'b0, 8'h40, 8'h3C, SEL_LEDS, 8'h00, 8'hA5, "led_no_strobe"};
    vecs[2] = '{1'b1, 8'h81, 8'h3C, SEL_SSEG, 8'h00, 8'h3C, "sseg_write"};
    vecs[3] = '{1'b1, 8'h7F, 8'h11, SEL_LEDS, 8'h00, 8'hA5, "unmapped_leds"};
    vecs[4] = '{1'b1, 8'h7F, 8'h11, SEL_SSEG, 8'h00, 8'h3C, "unmapped_sseg"};
    vecs[5] = '{1'b0, 8'h00, 8'h00, SEL_IN,   8'h7F, 8'h00, "read_unmapped"};
    vecs[6] = '{1'b1, 8'h40, 8'h5A, SEL_LEDS, 8'h00, 8'h5A, "led_rewrite"};
    vecs[7] = '{1'b1, 8'h24, 8'hFF, SEL_SSEG, 8'h00, 8'h3C, "write_readonly_id"};
    vecs[8] = '{1'b0, 8'h00, 8'h00, SEL_IN,   8'h25, 8'h00, "ist_idle"};
    vecs[9] = '{1'b1, 8'h83, 8'h0F, SEL_INT,  8'h00, 8'h00, "mask_no_pending"};

    RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    SWITCHES = 8'h00; BUTTONS = 4'h0;
    step(3);
    RESET = 1'b0;

    // Load everything, raise an interrupt, then reset with a colliding write.
    wr(8'h40, 8'hFF);
    wr(8'h81, 8'hFF);
    wr(8'h83, 8'h0F);
    wr(8'h30, 8'h55);
    BUTTONS = 4'h4;
    step(6);
    check_now(SEL_INT, 8'h00, 8'h01, "pre_reset_int");
    RESET = 1'b1; IO_STRB = 1'b1; PORT_ID = 8'h40; OUT_PORT = 8'h77;
    step(1);
    IO_STRB = 1'b0; BUTTONS = 4'h0;
    step(1);
    check_now(SEL_LEDS, 8'h00, 8'h00, "reset_leds");
    check_now(SEL_SSEG, 8'h00, 8'h00, "reset_sseg");
    check_now(SEL_IN,   8'h25, 8'h00, "reset_ist");
    check_now(SEL_INT,  8'h00, 8'h00, "reset_int_req");
    check_now(SEL_IN,   8'h30, 8'h00, "reset_tmr");
    RESET = 1'b0;
    step(4);
    check_now(SEL_IN, 8'h25, 8'h00, "post_reset_ist");

    for (int i = 0; i < 10; i++) begin
      IO_STRB = vecs[i].strb; PORT_ID = vecs[i].id; OUT_PORT = vecs[i].data;
      push(vecs[i].sel, vecs[i].rd_id, vecs[i].exp, vecs[i].name);
      @(negedge CLK);
      IO_STRB = 1'b0;
      drain();
    end

    // Switch synchronizer latency.
    PORT_ID = 8'h20; SWITCHES = 8'h5A;
    step(1);
    check_now(SEL_IN, 8'h20, 8'h00, "sw_sync_1cyc");
    step(1);
    check_now(SEL_IN, 8'h20, 8'h5A, "sw_sync_2cyc");

    // Press, clear while held, re-press.
    wr(8'h83, 8'h01);
    BUTTONS = 4'h1;
    step(10);
    check_now(SEL_IN,  8'h25, 8'h01, "press_ist");
    check_now(SEL_IN,  8'h24, 8'h01, "press_btn_read");
    check_now(SEL_INT, 8'h00, 8'h01, "press_int_req");
    wr(8'h82, 8'h01);
    check_now(SEL_IN, 8'h25, 8'h00, "clear_ist");
    step(1);
    check_now(SEL_INT, 8'h00, 8'h00, "clear_int_req");
    step(5);
    check_now(SEL_IN, 8'h25, 8'h00, "held_no_reset");
    BUTTONS = 4'h0;
    step(4);
    BUTTONS = 4'h1;
    step(4);
    check_now(SEL_IN, 8'h25, 8'h01, "repress_ist");
    BUTTONS = 4'h0;
    wr(8'h82, 8'h01);
    wr(8'h83, 8'h00);
    step(3);

    // Clear collides with the edge on button 1: the set must win.
    BUTTONS = 4'h2;
    step(2);
    IO_STRB = 1'b1; PORT_ID = 8'h82; OUT_PORT = 8'h02;
    step(1);
    IO_STRB = 1'b0;
    check_now(SEL_IN, 8'h25, 8'h02, "collision_set_wins");
    step(1);
    check_now(SEL_INT, 8'h00, 8'h00, "masked_no_int");
    wr(8'h83, 8'h02);
    check_now(SEL_INT, 8'h00, 8'h00, "mask_lag");
    step(1);
    check_now(SEL_INT, 8'h00, 8'h01, "mask_int_req");
    BUTTONS = 4'h0;

    // Timer load, tick and wrap, then reset mid-prescale.
    wr(8'h30, 8'hFE);
    step(3);
    check_now(SEL_IN, 8'h30, 8'hFE, "tmr_before_tick");
    step(1);
    check_now(SEL_IN, 8'h30, 8'hFF, "tmr_tick");
    step(4);
    check_now(SEL_IN, 8'h30, 8'h00, "tmr_wrap");
    wr(8'h30, 8'hFE);
    step(5);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    check_now(SEL_IN, 8'h30, 8'h00, "tmr_reset");
    step(3);
    check_now(SEL_IN, 8'h30, 8'h00, "tmr_restart_hold");
    step(1);
    check_now(SEL_IN, 8'h30, 8'h01, "tmr_restart_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
